// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared encodings for the reaction-timer controller: FSM state codes and the
// random-delay LFSR seed, tap mask and step function.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_REACT = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Board-side signal bundle of the reaction-timer controller. The best-time
// outputs exist only when REACT_BEST_TIME_EN is defined.
interface reaction_timer_ctrl_if;
    import reaction_timer_pkg::*;

    // Start is a synchronous level whose rising edge requests a trial; Pushn is
    // an asynchronous active-low level where only a new falling edge is a press.
    logic       Start;
    logic       Pushn;
    logic       LEDn;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
    logic       Busy;
    logic       FalseStart;
    logic       Overflow;
    state_t     dbg_state;
`ifdef REACT_BEST_TIME_EN
    logic [3:0] BestBCD1;
    logic [3:0] BestBCD0;
    logic       NewBest;

    modport master (
        output Start, Pushn,
        input  LEDn, BCD1, BCD0, Busy, FalseStart, Overflow, dbg_state,
        input  BestBCD1, BestBCD0, NewBest
    );
    modport slave (
        input  Start, Pushn,
        output LEDn, BCD1, BCD0, Busy, FalseStart, Overflow, dbg_state,
        output BestBCD1, BestBCD0, NewBest
    );
`else
    modport master (
        output Start, Pushn,
        input  LEDn, BCD1, BCD0, Busy, FalseStart, Overflow, dbg_state
    );
    modport slave (
        input  Start, Pushn,
        output LEDn, BCD1, BCD0, Busy, FalseStart, Overflow, dbg_state
    );
`endif

endinterface

// File: rtl/reaction_timer_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear; holds at 99 once reached.
module bcd2_counter (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Clear,
    input  logic       Inc,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic       AtMax
);

    logic [3:0] bcd1_q, bcd1_d;
    logic [3:0] bcd0_q, bcd0_d;

    assign AtMax = (bcd1_q == 4'd9) && (bcd0_q == 4'd9);

    always_comb begin
        bcd1_d = bcd1_q;
        bcd0_d = bcd0_q;
        if (Clear) begin
            bcd1_d = 4'd0;
            bcd0_d = 4'd0;
        end else if (Inc && !AtMax) begin
            if (bcd0_q == 4'd9) begin
                bcd0_d = 4'd0;
                bcd1_d = bcd1_q + 4'd1;
            end else begin
                bcd0_d = bcd0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bcd1_q <= 4'd0;
            bcd0_q <= 4'd0;
        end else begin
            bcd1_q <= bcd1_d;
            bcd0_q <= bcd0_d;
        end
    end

    assign BCD1 = bcd1_q;
    assign BCD0 = bcd0_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer trial sequencer: random wait, LED on, 10 ms BCD count, freeze on
// press. Define REACT_BEST_TIME_EN to add best-result tracking outputs.
module reaction_timer_ctrl #(
    parameter int TICK_DIV        = 500000,
    parameter int MIN_DELAY_TICKS = 100,
    parameter int DELAY_BITS      = 8
) (
    input logic                  Clock,
    input logic                  Reset,
    reaction_timer_ctrl_if.slave io
);
    import reaction_timer_pkg::*;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_TICKS + (1 << DELAY_BITS));
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DELAY_W-1:0] DELAY_MIN = DELAY_W'(MIN_DELAY_TICKS);

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [2:0]           push_sync_q, push_sync_d;
    logic                 start_prev_q, start_prev_d;
    logic                 led_n_q, led_n_d;
    logic                 busy_q, busy_d;
    logic                 false_start_q, false_start_d;
    logic                 overflow_q, overflow_d;
`ifdef REACT_BEST_TIME_EN
    logic [7:0]           best_q, best_d;
    logic                 new_best_q, new_best_d;
`endif

    logic       tick, press, start_edge, start_accept;
    logic       cnt_clear, cnt_inc, cnt_at_max;
    logic [3:0] bcd1, bcd0;

    bcd2_counter u_count (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (cnt_clear),
        .Inc   (cnt_inc),
        .BCD1  (bcd1),
        .BCD0  (bcd0),
        .AtMax (cnt_at_max)
    );

    always_comb begin
        tick          = (presc_q == TICK_LAST);
        // Stage 2 is the synchronised level; stage 3 only remembers it for edge detect.
        press         = push_sync_q[2] & ~push_sync_q[1];
        start_edge    = io.Start & ~start_prev_q;
        start_accept  = start_edge && (state_q == ST_IDLE || state_q == ST_DONE ||
                                       state_q == ST_FAULT);
        cnt_clear     = start_accept;
        cnt_inc       = 1'b0;
        state_d       = state_q;
        presc_d       = (tick || start_accept) ? '0 : presc_q + 1'b1;
        lfsr_d        = lfsr_next(lfsr_q);
        delay_d       = delay_q;
        push_sync_d   = {push_sync_q[1:0], io.Pushn};
        start_prev_d  = io.Start;
        led_n_d       = led_n_q;
        busy_d        = busy_q;
        false_start_d = false_start_q;
        overflow_d    = overflow_q;
`ifdef REACT_BEST_TIME_EN
        best_d        = best_q;
        new_best_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start_accept) begin
                    state_d       = ST_ARM;
                    delay_d       = DELAY_MIN + DELAY_W'(lfsr_q[DELAY_BITS-1:0]);
                    led_n_d       = 1'b1;
                    busy_d        = 1'b1;
                    false_start_d = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            ST_ARM: begin
                if (press) begin
                    state_d       = ST_FAULT;
                    busy_d        = 1'b0;
                    false_start_d = 1'b1;
                end else if (tick) begin
                    delay_d = delay_q - 1'b1;
                    if (delay_q == DELAY_W'(1)) begin
                        state_d = ST_REACT;
                        led_n_d = 1'b0;
                    end
                end
            end
            ST_REACT: begin
                if (press) begin
                    state_d = ST_DONE;
                    led_n_d = 1'b1;
                    busy_d  = 1'b0;
`ifdef REACT_BEST_TIME_EN
                    if ({bcd1, bcd0} < best_q) begin
                        best_d     = {bcd1, bcd0};
                        new_best_d = 1'b1;
                    end
`endif
                end else if (tick) begin
                    if (cnt_at_max) begin
                        state_d    = ST_DONE;
                        led_n_d    = 1'b1;
                        busy_d     = 1'b0;
                        overflow_d = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            presc_q       <= '0;
            lfsr_q        <= LFSR_SEED;
            delay_q       <= '0;
            push_sync_q   <= 3'b111;
            start_prev_q  <= 1'b0;
            led_n_q       <= 1'b1;
            busy_q        <= 1'b0;
            false_start_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef REACT_BEST_TIME_EN
            best_q        <= 8'h99;
            new_best_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            lfsr_q        <= lfsr_d;
            delay_q       <= delay_d;
            push_sync_q   <= push_sync_d;
            start_prev_q  <= start_prev_d;
            led_n_q       <= led_n_d;
            busy_q        <= busy_d;
            false_start_q <= false_start_d;
            overflow_q    <= overflow_d;
`ifdef REACT_BEST_TIME_EN
            best_q        <= best_d;
            new_best_q    <= new_best_d;
`endif
        end
    end

    assign io.LEDn       = led_n_q;
    assign io.BCD1       = bcd1;
    assign io.BCD0       = bcd0;
    assign io.Busy       = busy_q;
    assign io.FalseStart = false_start_q;
    assign io.Overflow   = overflow_q;
    assign io.dbg_state  = state_q;
`ifdef REACT_BEST_TIME_EN
    assign io.BestBCD1   = best_q[7:4];
    assign io.BestBCD0   = best_q[3:0];
    assign io.NewBest    = new_best_q;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl with a fast tick (TICK_DIV=4).
// Best-time checks are compiled in when REACT_BEST_TIME_EN is defined.
module tb_reaction_timer_ctrl;
    import reaction_timer_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int MIN_DELAY  = 2;
    localparam int DELAY_BITS = 2;
    localparam int MAX_TICKS  = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_timer_ctrl_if dut_if ();

    reaction_timer_ctrl #(
        .TICK_DIV        (TICK_DIV),
        .MIN_DELAY_TICKS (MIN_DELAY),
        .DELAY_BITS      (DELAY_BITS)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .io    (dut_if)
    );

    int         errors     = 0;
    int         checks     = 0;
    int         best_model = 99;
    int         nb_seen    = 0;
    logic [7:0] exp_q[$];
    logic [15:0] model_lfsr;

    // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge clk or posedge rst) begin
        if (rst) model_lfsr <= 16'hACE1;
        else     model_lfsr <= {model_lfsr[14:0],
                                model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    end

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // One trial from a quiescent negedge. mode 0: never press; 1: pin falls at
    // cycle arg after accept; 2: press registers arg cycles after the LED edge.
    task automatic run_trial(input int mode, input int arg, input int ign, input bit ign_rel);
        int d, press_c, p, end_c, result, ovf_edge, ign_c, n;
        bit fault, ovf, nb;
        logic [15:0] seed;
        logic [7:0]  got_bcd, want_bcd, e_bcd;
        state_t      e_st;
        logic        e_led, e_busy, e_fs, e_ov;
        dut_if.Start = 1'b1;
        seed     = model_lfsr;
        d        = MIN_DELAY + int'(seed[DELAY_BITS-1:0]);
        press_c  = (mode == 1) ? arg : 4 * d + arg - 3;
        p        = press_c + 3;
        ovf_edge = 4 * (d + MAX_TICKS);
        fault    = (mode != 0) && (p <= 4 * d);
        ovf      = !fault && ((mode == 0) || (p > ovf_edge));
        end_c    = ovf ? ovf_edge : p;
        result   = fault ? 0 : (ovf ? 99 : (p - 1) / 4 - d);
        nb       = !fault && !ovf && (result < best_model);
        ign_c    = ign_rel ? 4 * d + ign : ign;
        if (ign_c < 1 || ign_c + 1 >= end_c) ign_c = -10;
        exp_q.push_back(to_bcd(result));
        e_st = ST_ARM; e_led = 1'b1; e_busy = 1'b1; e_fs = 1'b0; e_ov = 1'b0; e_bcd = 8'h00;
        @(negedge clk);
        dut_if.Start = 1'b0;
        for (int c = 0; c <= end_c + 2; c++) begin
            if (mode != 0 && c == press_c) dut_if.Pushn = 1'b0;
            if (c == ign_c)                dut_if.Start = 1'b1;
            if (c == ign_c + 1)            dut_if.Start = 1'b0;
            if (c >= end_c) begin
                e_st = fault ? ST_FAULT : ST_DONE;
                e_led = 1'b1; e_busy = 1'b0; e_fs = fault; e_ov = ovf; e_bcd = to_bcd(result);
            end else if (c >= 4 * d) begin
                n = c / 4 - d;
                e_st = ST_REACT; e_led = 1'b0; e_busy = 1'b1; e_fs = 1'b0; e_ov = 1'b0;
                e_bcd = to_bcd(n);
            end else begin
                e_st = ST_ARM; e_led = 1'b1; e_busy = 1'b1; e_fs = 1'b0; e_ov = 1'b0;
                e_bcd = 8'h00;
            end
            checks++;
            if ({dut_if.dbg_state, dut_if.LEDn, dut_if.BCD1, dut_if.BCD0, dut_if.Busy,
                 dut_if.FalseStart, dut_if.Overflow} !== {e_st, e_led, e_bcd, e_busy, e_fs, e_ov}) begin
                errors++;
                $display("FAIL trial c=%0d d=%0d: got st=%0d led=%b bcd=%h busy=%b fs=%b ov=%b, want st=%0d led=%b bcd=%h busy=%b fs=%b ov=%b",
                         c, d, dut_if.dbg_state, dut_if.LEDn, {dut_if.BCD1, dut_if.BCD0}, dut_if.Busy,
                         dut_if.FalseStart, dut_if.Overflow, e_st, e_led, e_bcd, e_busy, e_fs, e_ov);
            end
`ifdef REACT_BEST_TIME_EN
            begin
                logic [7:0] e_best;
                logic       e_nb;
                e_best = (nb && c >= end_c) ? to_bcd(result) : to_bcd(best_model);
                e_nb   = nb && (c == end_c);
                if (dut_if.NewBest === 1'b1) nb_seen++;
                checks++;
                if ({dut_if.BestBCD1, dut_if.BestBCD0, dut_if.NewBest} !== {e_best, e_nb}) begin
                    errors++;
                    $display("FAIL best c=%0d: got best=%h new=%b, want best=%h new=%b",
                             c, {dut_if.BestBCD1, dut_if.BestBCD0}, dut_if.NewBest, e_best, e_nb);
                end
            end
`endif
            @(negedge clk);
        end
        if (nb) best_model = result;
        got_bcd  = {dut_if.BCD1, dut_if.BCD0};
        want_bcd = exp_q.pop_front();
        checks++;
        if (got_bcd !== want_bcd) begin
            errors++;
            $display("FAIL trial_result: got %h want %h", got_bcd, want_bcd);
        end
        // Release, then press again while finished: must have no effect.
        dut_if.Pushn = 1'b1;
        repeat (4) @(negedge clk);
        dut_if.Pushn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({dut_if.dbg_state, dut_if.LEDn, dut_if.BCD1, dut_if.BCD0, dut_if.FalseStart,
             dut_if.Overflow} !== {e_st, e_led, e_bcd, e_fs, e_ov}) begin
            errors++;
            $display("FAIL press_ignored: got st=%0d bcd=%h fs=%b ov=%b, want st=%0d bcd=%h fs=%b ov=%b",
                     dut_if.dbg_state, {dut_if.BCD1, dut_if.BCD0}, dut_if.FalseStart, dut_if.Overflow,
                     e_st, e_bcd, e_fs, e_ov);
        end
        dut_if.Pushn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        dut_if.Start = 1'b0;
        dut_if.Pushn = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dut_if.dbg_state, dut_if.LEDn, dut_if.BCD1, dut_if.BCD0, dut_if.Busy,
             dut_if.FalseStart, dut_if.Overflow} !== {ST_IDLE, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got st=%0d led=%b bcd=%h busy=%b fs=%b ov=%b, want idle/1/00/0/0/0",
                     dut_if.dbg_state, dut_if.LEDn, {dut_if.BCD1, dut_if.BCD0}, dut_if.Busy,
                     dut_if.FalseStart, dut_if.Overflow);
        end
`ifdef REACT_BEST_TIME_EN
        checks++;
        if ({dut_if.BestBCD1, dut_if.BestBCD0, dut_if.NewBest} !== {8'h99, 1'b0}) begin
            errors++;
            $display("FAIL reset_best: got %h/%b want 99/0", {dut_if.BestBCD1, dut_if.BestBCD0}, dut_if.NewBest);
        end
`endif
        rst = 1'b0;
        best_model = 99;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_react();
        int d;
        logic [15:0] seed;
        dut_if.Start = 1'b1;
        seed = model_lfsr;
        d = MIN_DELAY + int'(seed[DELAY_BITS-1:0]);
        @(negedge clk);
        dut_if.Start = 1'b0;
        repeat (4 * d + 10) @(negedge clk);
        checks++;
        if ({dut_if.dbg_state, dut_if.LEDn, dut_if.BCD1, dut_if.BCD0} !== {ST_REACT, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL pre_reset_react: got st=%0d led=%b bcd=%h want st=2 led=0 bcd=02",
                     dut_if.dbg_state, dut_if.LEDn, {dut_if.BCD1, dut_if.BCD0});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dut_if.dbg_state, dut_if.LEDn, dut_if.BCD1, dut_if.BCD0, dut_if.Busy,
             dut_if.FalseStart, dut_if.Overflow} !== {ST_IDLE, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_react: got st=%0d led=%b bcd=%h busy=%b fs=%b ov=%b, want idle/1/00/0/0/0",
                     dut_if.dbg_state, dut_if.LEDn, {dut_if.BCD1, dut_if.BCD0}, dut_if.Busy,
                     dut_if.FalseStart, dut_if.Overflow);
        end
        rst = 1'b0;
        best_model = 99;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_trial();
        int waited = 0;
        while (model_lfsr[1:0] != 2'd1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            checks++;
            errors++;
            $display("FAIL lfsr_wait: got no LFSR[1:0]=1 within %0d cycles, want one", waited);
        end
        // delay=3 ticks; pin falls 39 cycles after accept -> 7 counted ticks.
        run_trial(1, 39, -1, 1'b0);
        checks++;
        if ({dut_if.dbg_state, dut_if.BCD1, dut_if.BCD0, dut_if.Busy} !== {ST_DONE, 8'h07, 1'b0}) begin
            errors++;
            $display("FAIL basic_done: got st=%0d bcd=%h busy=%b want st=3 bcd=07 busy=0",
                     dut_if.dbg_state, {dut_if.BCD1, dut_if.BCD0}, dut_if.Busy);
        end
    endtask

    task automatic test_false_start();
        run_trial(1, 2, -1, 1'b0);
        run_trial(2, 0, 2, 1'b0);
        run_trial(2, 9, -1, 1'b0);
    endtask

    task automatic test_overflow();
        run_trial(0, 0, 2, 1'b1);
    endtask

    task automatic test_press_on_tick();
        run_trial(2, 20, 3, 1'b0);
        run_trial(2, 4, 1, 1'b1);
    endtask

    task automatic test_held_button();
        dut_if.Pushn = 1'b0;
        repeat (6) @(negedge clk);
        run_trial(0, 0, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_trial(2, int'($urandom_range(0, 70)) - 5, int'($urandom_range(1, 6)), 1'b0);
        end
    endtask

`ifdef REACT_BEST_TIME_EN
    task automatic test_best();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        best_model = 99;
        nb_seen = 0;
        @(negedge clk);
        run_trial(2, 4 * 12 + 2, -1, 1'b0);
        checks++;
        if ({dut_if.BestBCD1, dut_if.BestBCD0} !== 8'h12) begin
            errors++;
            $display("FAIL best_12: got %h want 12", {dut_if.BestBCD1, dut_if.BestBCD0});
        end
        run_trial(2, 4 * 8 + 2, -1, 1'b0);
        checks++;
        if ({dut_if.BestBCD1, dut_if.BestBCD0} !== 8'h08) begin
            errors++;
            $display("FAIL best_08: got %h want 08", {dut_if.BestBCD1, dut_if.BestBCD0});
        end
        run_trial(2, 4 * 10 + 2, -1, 1'b0);
        checks++;
        if ({dut_if.BestBCD1, dut_if.BestBCD0} !== 8'h08) begin
            errors++;
            $display("FAIL best_stays_08: got %h want 08", {dut_if.BestBCD1, dut_if.BestBCD0});
        end
        checks++;
        if (nb_seen !== 2) begin
            errors++;
            $display("FAIL new_best_pulses: got %0d want 2", nb_seen);
        end
    endtask
`endif

    initial begin
        dut_if.Start = 1'b0;
        dut_if.Pushn = 1'b1;
        test_reset();
        test_basic_trial();
        test_false_start();
        test_overflow();
        test_press_on_tick();
        test_held_button();
        test_back_to_back();
        test_reset_mid_react();
        run_trial(2, 13, -1, 1'b0);
`ifdef REACT_BEST_TIME_EN
        test_best();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
